// File: rtl/refill_line_writer.sv
// Refill write stage: collects a wrapping 64-bit burst and writes it to the data RAM.
// Optional critical-word forwarding is enabled with `define REFILL_CRIT_FWD_EN.
module refill_line_writer #(
    parameter  int SET_NUM    = 64,
    parameter  int LINE_WORDS = 8,
    localparam int IDX_W      = $clog2(SET_NUM),
    localparam int OFF_W      = $clog2(LINE_WORDS),
    localparam int AW         = IDX_W + OFF_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_index,
    input  logic [OFF_W-1:0] req_offset,
    input  logic             r_valid,
    output logic             r_ready,
    input  logic [63:0]      r_data,
    input  logic             r_last,
    output logic             ram_wen,
    output logic [AW-1:0]    ram_waddr,
    output logic [63:0]      ram_wdata,
    output logic             done,
    output logic             err,
    output logic             crit_valid,
    output logic [63:0]      crit_data
);

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic               eacc_q, eacc_d;
    logic               wen_q, wen_d;
    logic [AW-1:0]      waddr_q, waddr_d;
    logic [63:0]        wdata_q, wdata_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               start;
    logic               beat;

    assign start = (state_q == IDLE) && req_valid;
    assign beat  = (state_q == FILL) && r_valid;

    // Next-state, write-port and handshake logic; r_ready comes from state only
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        eacc_d    = eacc_q;
        wen_d     = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        req_ready = 1'b0;
        r_ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    idx_d   = req_index;
                    off_d   = req_offset;
                    cnt_d   = '0;
                    eacc_d  = 1'b0;
                    state_d = FILL;
                end
            end
            FILL: begin
                r_ready = 1'b1;
                if (r_valid) begin
                    wen_d   = 1'b1;
                    waddr_d = {idx_q, off_q};
                    wdata_d = r_data;
                    off_d   = off_q + OFF_W'(1);
                    cnt_d   = cnt_q + OFF_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        err_d   = eacc_q | ~r_last;
                    end else begin
                        eacc_d = eacc_q | r_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered RAM write port; reset clears a write in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            eacc_q  <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            eacc_q  <= eacc_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ram_wen   = wen_q;
    assign ram_waddr = waddr_q;
    assign ram_wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;

`ifdef REFILL_CRIT_FWD_EN
    logic        first_q;
    logic        cv_q;
    logic [63:0] cd_q;

    // Forward the first accepted beat of each fill one cycle after accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= 1'b0;
            cv_q    <= 1'b0;
            cd_q    <= '0;
        end else begin
            cv_q <= 1'b0;
            if (start) begin
                first_q <= 1'b1;
            end else if (beat) begin
                first_q <= 1'b0;
                if (first_q) begin
                    cv_q <= 1'b1;
                    cd_q <= r_data;
                end
            end
        end
    end

    assign crit_valid = cv_q;
    assign crit_data  = cd_q;
`else
    assign crit_valid = 1'b0;
    assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_refill_line_writer.sv
// Scoreboard bench for refill_line_writer: driver pushes expected writes,
// a negedge monitor pops and compares them against the RAM write port.
module tb_refill_line_writer;

    localparam int LW    = 8;
    localparam int IDX_W = 6;
    localparam int OFF_W = 3;
    localparam int AW    = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [IDX_W-1:0] req_index = '0;
    logic [OFF_W-1:0] req_offset = '0;
    logic             r_valid = 1'b0;
    logic             r_ready;
    logic [63:0]      r_data = '0;
    logic             r_last = 1'b0;
    logic             ram_wen;
    logic [AW-1:0]    ram_waddr;
    logic [63:0]      ram_wdata;
    logic             done;
    logic             err;
    logic             crit_valid;
    logic [63:0]      crit_data;

    refill_line_writer #(.SET_NUM(64), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_offset(req_offset),
        .r_valid(r_valid), .r_ready(r_ready),
        .r_data(r_data), .r_last(r_last),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .done(done), .err(err),
        .crit_valid(crit_valid), .crit_data(crit_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [63:0]   data;
        logic          dn;
        logic          er;
        logic          first;
        int            gap;
    } exp_t;

    exp_t   sbq[$];
    exp_t   me;
    int     total = 0;
    int     bad = 0;
    longint cyc = 0;
    longint last_done = -100;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (ram_wen) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_write actual=%0d required=none",
                             ram_waddr);
                end else begin
                    me = sbq.pop_front();
                    chk("waddr", 64'(ram_waddr), 64'(me.addr));
                    chk("wdata", ram_wdata, me.data);
                    chk("done", 64'(done), 64'(me.dn));
                    chk("err", 64'(err), 64'(me.er));
                    if (me.dn) chk("done_req_ready", 64'(req_ready), 64'd1);
                    if (me.gap > 0)
                        chk("b2b_gap", 64'(cyc - last_done), 64'(me.gap));
`ifdef REFILL_CRIT_FWD_EN
                    chk("crit_valid", 64'(crit_valid), 64'(me.first));
                    if (me.first) chk("crit_data", crit_data, me.data);
`else
                    chk("crit_valid_off", 64'(crit_valid), 64'd0);
                    chk("crit_data_off", crit_data, 64'd0);
`endif
                    if (me.dn) last_done = cyc;
                end
            end else begin
                chk("done_no_wen", 64'(done), 64'd0);
                chk("err_no_wen", 64'(err), 64'd0);
                chk("crit_no_wen", 64'(crit_valid), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fill(input int idx, input int off, input int gmode,
                           input int lastpos, input int gapchk,
                           input int stop_after, input int hidx,
                           input int hoff);
        int          w;
        logic [63:0] d;
        bit          lst;
        bit          eacc;
        exp_t        e;
        req_valid  = 1'b1;
        req_index  = IDX_W'(idx);
        req_offset = OFF_W'(off);
        w = 0;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL req_timeout actual=0 required=1");
        end
        tick();
        req_valid = 1'b0;
        if (hidx >= 0) begin
            req_valid  = 1'b1;
            req_index  = IDX_W'(hidx);
            req_offset = OFF_W'(hoff);
        end
        eacc = 1'b0;
        for (int i = 0; i < LW; i++) begin
            if (stop_after >= 0 && i >= stop_after) break;
            if (gmode == 1 && i > 0) begin
                r_valid = 1'b0;
                tick();
            end else if (gmode == 2) begin
                r_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            d   = {$urandom, $urandom};
            lst = (i == lastpos);
            r_valid = 1'b1;
            r_data  = d;
            r_last  = lst;
            e.addr  = AW'(idx * LW + (off + i) % LW);
            e.data  = d;
            e.dn    = (i == LW - 1);
            e.er    = (i == LW - 1) && (!lst || eacc);
            e.first = (i == 0);
            e.gap   = (i == 0) ? gapchk : 0;
            sbq.push_back(e);
            eacc = eacc | lst;
            tick();
        end
        r_valid = 1'b0;
        r_last  = 1'b0;
    endtask

    initial begin
        #1000000;
        total++;
        bad++;
        $display("FAIL watchdog actual=running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int w;
        #1;
        chk("rst_wen", 64'(ram_wen), 64'd0);
        chk("rst_waddr", 64'(ram_waddr), 64'd0);
        chk("rst_wdata", ram_wdata, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_crit_v", 64'(crit_valid), 64'd0);
        chk("rst_crit_d", crit_data, 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_r_ready", 64'(r_ready), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        do_fill(5, 0, 0, 7, 0, -1, -1, 0);
        do_fill(3, 6, 0, 7, 0, -1, -1, 0);
        do_fill(10, 3, 1, 7, 0, -1, -1, 0);
        do_fill(12, 5, 0, 3, 0, -1, -1, 0);

        do_fill(7, 1, 0, 7, 0, 5, -1, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_wen", 64'(ram_wen), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_waddr", 64'(ram_waddr), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);
        r_valid = 1'b1;
        r_data  = 64'hdead_beef_0bad_f00d;
        chk("idle_r_ready", 64'(r_ready), 64'd0);
        tick();
        tick();
        r_valid = 1'b0;
        do_fill(7, 2, 0, 7, 0, -1, -1, 0);

        do_fill(20, 4, 0, 7, 0, -1, 21, 5);
        do_fill(21, 5, 0, 7, 2, -1, -1, 0);

        for (int k = 0; k < 30; k++) begin
            int lp;
            lp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : 7;
            do_fill($urandom_range(0, 63), $urandom_range(0, 7),
                    $urandom_range(0, 2), lp, 0, -1, -1, 0);
        end

        w = 0;
        while (sbq.size() != 0 && w < 20) begin
            tick();
            w++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d required=0", sbq.size());
        end
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/refill_line_writer.md
Name: refill_line_writer

Overview:
- Cache refill write stage that sits directly upstream of the 64-bit simple dual-port data RAM (write port: wen/wAddr/wdata).
- Accepts a refill request (set index plus critical-word offset), then collects a wrapping 64-bit read burst from the bus interface.
- Writes each beat into the RAM, one beat per write, at address {index, offset}, and signals line completion to the cache controller.

Parameters:
- SET_NUM, 64, number of sets; index width IDX_W = $clog2(SET_NUM).
- LINE_WORDS, 8, 64-bit beats per line (power of 2, >= 2); offset width OFF_W = $clog2(LINE_WORDS).
- Derived: RAM address width AW = IDX_W + OFF_W, which must equal the RAM's $clog2(MY_NUMBER).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  refill request
- req_ready  out  1  high in IDLE
- req_index  in  IDX_W  set to refill
- req_offset  in  OFF_W  critical word offset; burst starts here
- r_valid  in  1  bus beat valid
- r_ready  out  1  beat accept
- r_data  in  64  beat data
- r_last  in  1  bus last-beat flag
- ram_wen  out  1  to RAM wen
- ram_waddr  out  AW  to RAM wAddr, {index, offset}
- ram_wdata  out  64  to RAM wdata
- done  out  1  one-cycle pulse: line fully written
- err  out  1  one-cycle pulse with done: r_last mismatch
- crit_valid  out  1  critical word forward strobe (optional feature)
- crit_data  out  64  critical word data (optional feature)

Behaviour:
- Reset: asynchronous and active-low, as already decided. All of the following are 0 while rst_n is low: state=IDLE, ram_wen, ram_waddr, ram_wdata, done, err, crit_valid, crit_data, beat counter.
- States:
  - IDLE: req_ready=1, r_ready=0. When req_valid=1, latch index and offset, clear beat count, go to FILL.
  - FILL: req_ready=0, r_ready=1. A beat is accepted when r_valid && r_ready.
  - DONE: not used; completion happens in the cycle after the final accept.
- Beat accepted in cycle N:
  - Cycle N+1 registered outputs: ram_wen=1, ram_waddr={idx, off}, ram_wdata=r_data. Write latency is 1 cycle.
  - off advances as (off+1) mod LINE_WORDS, wrapping within the line and never carrying into idx.
  - count increments.
- ram_wen is 0 in every cycle that did not follow an accept. Gaps in r_valid produce gaps in writes, with no stale writes.
- Final beat (count == LINE_WORDS-1 at accept, cycle N):
  - State returns to IDLE at N+1.
  - done=1 at N+1, coinciding with the final ram_wen.
  - req_ready=1 at N+1. A new request accepted at N+1 starts FILL at N+2, giving back-to-back refills with a 1-cycle bubble.
- Termination is by beat count only. err=1 with done if r_last=0 on the final beat, or if r_last=1 on any earlier beat. An early r_last does not terminate the fill.
- req_valid while in FILL is ignored; the request is not latched and the upstream holds it.
- r_valid while in IDLE is ignored (r_ready=0).
- Reset asserted mid-FILL:
  - Immediate return to IDLE, with ram_wen forced to 0 asynchronously.
  - The partially written line is not invalidated here; tag/valid ownership stays with the cache controller.
- No combinational path from r_valid to ram_wen.
- r_ready depends only on state.

Optional Feature:
- Macro: REFILL_CRIT_FWD_EN.
- Defined: on the first accepted beat of each fill (the req_offset word), crit_valid=1 for exactly one cycle at N+1 and crit_data=r_data, so the pipeline can restart before done.
- Not defined: crit_valid and crit_data are tied to 0, with no forwarding registers instantiated.

Test Plan:
- Request idx=5, off=0, 8 beats D0..D7 on consecutive cycles with r_last on beat 7:
  - ram_waddr sequence 40..47 (each beat's write at the cycle after its accept).
  - done and no err, one cycle after the last accept.
  - req_ready=1 in that same cycle.
- Request idx=3, off=6: waddr sequence 30,31,24,25,26,27,28,29. With REFILL_CRIT_FWD_EN, crit_valid pulses once with the beat-0 data, one cycle after the first accept.
- r_valid toggling 1,0,1,0 during a fill: ram_wen=1 only in the cycles following accepts, and exactly 8 writes in total.
- r_last asserted on beat 3 and absent on beat 7: the fill continues through 8 beats, then done=1 and err=1 in the same cycle.
- rst_n driven low after beat 4:
  - ram_wen=0 immediately and req_ready=1 after release.
  - A new request then restarts at its own offset with count=0.
- done cycle with req_valid held high:
  - The next fill is accepted in the done cycle.
  - First write of the new line 2 cycles later.
  - No write overlap with the previous line.
